local_ctrl_gen: RTL



---
 rtl/local_ctrl_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/local_ctrl_gen.sv
// Local PU controller: sequences operand reads row by row and frames each accumulation
// with valid/clear strobes. Optional stall counter enabled by LOCAL_CTRL_STALL_CNT_EN.
module local_ctrl_gen #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ROWS    = 8,
  parameter int unsigned ACC_LEN = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              pu_en_i,
  output logic [ADDR_W-1:0] din_addr_o,
  output logic              din_en_o,
  output logic              pu_valid_o,
  output logic              pu_clear_o,
  output logic              busy_o,
`ifdef LOCAL_CTRL_STALL_CNT_EN
  output logic [15:0]       stall_cnt_o,
`endif
  output logic              done_o
);

  localparam int unsigned RowW = ($clog2(ROWS + 1) > 0) ? $clog2(ROWS + 1) : 1;
  localparam int unsigned BeatW = ($clog2(ACC_LEN + 1) > 0) ? $clog2(ACC_LEN + 1) : 1;

  localparam logic [RowW-1:0]  RowLast  = RowW'(ROWS - 1);
  localparam logic [RowW-1:0]  RowOne   = RowW'(1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(ACC_LEN - 1);
  localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StValid = 3'd2;
  localparam logic [2:0] StClear = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              start_ok;
  assign start_ok = (state_q == StIdle) && start_i && !abort_i;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    beat_d  = beat_q;
    base_d  = base_q;
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            base_d  = base_addr_i;
            row_d   = '0;
            beat_d  = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (pu_en_i) begin
            if (beat_q == BeatLast) begin
              beat_d  = '0;
              state_d = StValid;
            end else begin
              beat_d = beat_q + BeatOne;
            end
          end
        end
        StValid: state_d = StClear;
        StClear: begin
          if (row_q == RowLast) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + RowOne;
            state_d = StRun;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  logic              din_en_d;
  logic [ADDR_W-1:0] din_addr_d;
  always_comb begin
    din_en_d   = (state_d == StRun);
    din_addr_d = din_en_d ? (base_d + ADDR_W'(row_d)) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      row_q      <= '0;
      beat_q     <= '0;
      base_q     <= '0;
      din_addr_o <= '0;
      din_en_o   <= 1'b0;
      pu_valid_o <= 1'b0;
      pu_clear_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      din_addr_o <= din_addr_d;
      din_en_o   <= din_en_d;
      pu_valid_o <= (state_d == StValid);
      pu_clear_o <= (state_d == StClear);
      busy_o     <= (state_d != StIdle);
      done_o     <= (state_d == StDone);
    end
  end

`ifdef LOCAL_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StRun) && !pu_en_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
